// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge bus.
//   imem_req_o  : fetch stage -> memory, a request is outstanding
//   imem_addr_o : fetch stage -> memory, address of the outstanding request
//   imem_ack_i  : memory -> fetch stage, current request completes this cycle
//   imem_data_i : memory -> fetch stage, instruction word, valid with ack
// The fetch stage connects through the master modport; a memory model
// connects through the slave modport.
interface fetch_stage_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_ack_i,
    input  imem_data_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_ack_i,
    output imem_data_i
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage plus IF/ID pipeline register of the RV32 core.
// Issues requests to instruction memory over a variable-latency req/ack
// handshake and presents the fetched word, its PC and a valid flag to decode.
//
// Ports:
//   clk_i           : clock, all state updates on the rising edge
//   rst_i           : asynchronous active-low reset
//   start_i         : leave IDLE and begin fetching on the first edge it is high
//   stall_i         : hold IF/ID and the fetch PC (load-use hazard)
//   branch_i        : redirect request from ID, overrides stall_i
//   branch_target_i : redirect address, sampled when branch_i=1
//   imem            : instruction memory bus (master side)
//   IFID_pc_o       : PC of the instruction in IF/ID
//   IFID_instr_o    : instruction in IF/ID (NOP_INSTR when invalid)
//   IFID_valid_o    : IF/ID holds a real instruction
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                stall_i,
  input  logic                branch_i,
  input  logic [31:0]         branch_target_i,
  fetch_stage_if.master       imem,
  output logic [31:0]         IFID_pc_o,
  output logic [31:0]         IFID_instr_o,
  output logic                IFID_valid_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  state_e      state_q;
  logic [31:0] fetch_pc_q;   // redirect address waiting for the killed request to finish
  logic        kill_q;       // outstanding request belongs to a squashed path
  logic        req_q;
  logic [31:0] addr_q;
  logic [31:0] ifid_pc_q;
  logic [31:0] ifid_instr_q;
  logic        ifid_valid_q;
  logic [31:0] skid_pc_q;    // word accepted from memory while decode was stalled
  logic [31:0] skid_instr_q;

  assign imem.imem_req_o  = req_q;
  assign imem.imem_addr_o = addr_q;
  assign IFID_pc_o        = ifid_pc_q;
  assign IFID_instr_o     = ifid_instr_q;
  assign IFID_valid_o     = ifid_valid_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= S_IDLE;
      fetch_pc_q   <= RESET_PC;
      kill_q       <= 1'b0;
      req_q        <= 1'b0;
      addr_q       <= 32'h0;
      ifid_pc_q    <= 32'h0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
      skid_pc_q    <= 32'h0;
      skid_instr_q <= 32'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q <= S_FETCH;
            req_q   <= 1'b1;
            addr_q  <= fetch_pc_q;
          end
        end

        S_FETCH: begin
          if (branch_i && imem.imem_ack_i) begin
            // The completing request is on the wrong path; reissue at the target now.
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= NOP_INSTR;
            addr_q       <= branch_target_i;
            fetch_pc_q   <= branch_target_i + 32'd4;
            kill_q       <= 1'b0;
          end else if (branch_i) begin
            // Memory cannot abandon a request: remember the target and
            // discard the word when it eventually arrives.
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= NOP_INSTR;
            fetch_pc_q   <= branch_target_i;
            kill_q       <= 1'b1;
          end else if (imem.imem_ack_i && kill_q) begin
            kill_q     <= 1'b0;
            addr_q     <= fetch_pc_q;
            fetch_pc_q <= fetch_pc_q + 32'd4;
            if (!stall_i) begin
              ifid_valid_q <= 1'b0;
              ifid_instr_q <= NOP_INSTR;
            end
          end else if (imem.imem_ack_i && !stall_i) begin
            ifid_pc_q    <= addr_q;
            ifid_instr_q <= imem.imem_data_i;
            ifid_valid_q <= 1'b1;
            addr_q       <= addr_q + 32'd4;
          end else if (imem.imem_ack_i) begin
            // Decode is stalled: park the word and stop requesting.
            skid_pc_q    <= addr_q;
            skid_instr_q <= imem.imem_data_i;
            state_q      <= S_HOLD;
            req_q        <= 1'b0;
          end else if (!stall_i) begin
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= NOP_INSTR;
          end
        end

        S_HOLD: begin
          if (branch_i) begin
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= NOP_INSTR;
            addr_q       <= branch_target_i;
            fetch_pc_q   <= branch_target_i + 32'd4;
            state_q      <= S_FETCH;
            req_q        <= 1'b1;
          end else if (!stall_i) begin
            ifid_pc_q    <= skid_pc_q;
            ifid_instr_q <= skid_instr_q;
            ifid_valid_q <= 1'b1;
            addr_q       <= skid_pc_q + 32'd4;
            state_q      <= S_FETCH;
            req_q        <= 1'b1;
          end
        end

        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        branch_i = 1'b0;
  logic [31:0] branch_target_i = 32'h0;
  logic [31:0] IFID_pc_o;
  logic [31:0] IFID_instr_o;
  logic        IFID_valid_o;

  fetch_stage_if bus ();

  fetch_stage dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .start_i         (start_i),
    .stall_i         (stall_i),
    .branch_i        (branch_i),
    .branch_target_i (branch_target_i),
    .imem            (bus),
    .IFID_pc_o       (IFID_pc_o),
    .IFID_instr_o    (IFID_instr_o),
    .IFID_valid_o    (IFID_valid_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        start;
    logic        stall;
    logic        branch;
    logic [31:0] target;
    logic        ack;
    logic [31:0] data;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic        exp_valid;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] w(input logic [31:0] pc);
    return 32'hD000_0000 + pc;
  endfunction

  task automatic add(input logic st, input logic sl, input logic br, input logic [31:0] tg,
                     input logic ak, input logic [31:0] dt, input logic rq, input logic [31:0] ad,
                     input logic [31:0] pc, input logic [31:0] ins, input logic vl);
    vec_t v;
    v.start = st; v.stall = sl; v.branch = br; v.target = tg; v.ack = ak; v.data = dt;
    v.exp_req = rq; v.exp_addr = ad; v.exp_pc = pc; v.exp_instr = ins; v.exp_valid = vl;
    vecs.push_back(v);
  endtask

  task automatic check_outputs(input string tag, input logic rq, input logic [31:0] ad,
                               input logic [31:0] pc, input logic [31:0] ins, input logic vl);
    checks++;
    if (bus.imem_req_o !== rq) begin
      errors++;
      $display("FAIL %s req: got %b want %b", tag, bus.imem_req_o, rq);
    end
    checks++;
    if (bus.imem_addr_o !== ad) begin
      errors++;
      $display("FAIL %s addr: got %h want %h", tag, bus.imem_addr_o, ad);
    end
    checks++;
    if (IFID_pc_o !== pc) begin
      errors++;
      $display("FAIL %s ifid_pc: got %h want %h", tag, IFID_pc_o, pc);
    end
    checks++;
    if (IFID_instr_o !== ins) begin
      errors++;
      $display("FAIL %s ifid_instr: got %h want %h", tag, IFID_instr_o, ins);
    end
    checks++;
    if (IFID_valid_o !== vl) begin
      errors++;
      $display("FAIL %s ifid_valid: got %b want %b", tag, IFID_valid_o, vl);
    end
  endtask

  task automatic drive(input logic st, input logic sl, input logic br, input logic [31:0] tg,
                       input logic ak, input logic [31:0] dt);
    start_i = st; stall_i = sl; branch_i = br; branch_target_i = tg;
    bus.imem_ack_i = ak; bus.imem_data_i = dt;
  endtask

  initial begin
    bus.imem_ack_i  = 1'b0;
    bus.imem_data_i = 32'h0;

    //   st sl br target        ack data                req addr          ifid_pc       instr         v
    // zero-latency acks, back-to-back
    add(1, 0, 0, 32'h0,        0, 32'h0,             1, 32'h0,         32'h0,        NOP,          0);
    add(0, 0, 0, 32'h0,        1, w(32'h0),          1, 32'h4,         32'h0,        w(32'h0),     1);
    add(0, 0, 0, 32'h0,        1, w(32'h4),          1, 32'h8,         32'h4,        w(32'h4),     1);
    add(0, 0, 0, 32'h0,        1, w(32'h8),          1, 32'hC,         32'h8,        w(32'h8),     1);
    add(0, 0, 0, 32'h0,        1, w(32'hC),          1, 32'h10,        32'hC,        w(32'hC),     1);
    // three-cycle latency: two bubbles between valid words
    add(0, 0, 0, 32'h0,        0, 32'h0,             1, 32'h10,        32'hC,        NOP,          0);
    add(0, 0, 0, 32'h0,        0, 32'h0,             1, 32'h10,        32'hC,        NOP,          0);
    add(0, 0, 0, 32'h0,        1, w(32'h10),         1, 32'h14,        32'h10,       w(32'h10),    1);
    add(0, 0, 0, 32'h0,        0, 32'h0,             1, 32'h14,        32'h10,       NOP,          0);
    add(0, 0, 0, 32'h0,        0, 32'h0,             1, 32'h14,        32'h10,       NOP,          0);
    add(0, 0, 0, 32'h0,        1, w(32'h14),         1, 32'h18,        32'h14,       w(32'h14),    1);
    // stall while the 0x18 ack arrives: skid, req drops, IF/ID holds 0x14
    add(1, 1, 0, 32'h0,        1, w(32'h18),         0, 32'h18,        32'h14,       w(32'h14),    1);
    add(0, 1, 0, 32'h0,        0, 32'h0,             0, 32'h18,        32'h14,       w(32'h14),    1);
    add(0, 1, 0, 32'h0,        0, 32'h0,             0, 32'h18,        32'h14,       w(32'h14),    1);
    add(0, 1, 0, 32'h0,        0, 32'h0,             0, 32'h18,        32'h14,       w(32'h14),    1);
    add(0, 0, 0, 32'h0,        0, 32'h0,             1, 32'h1C,        32'h18,       w(32'h18),    1);
    // branch one cycle before the ack of the outstanding 0x1C request
    add(0, 0, 0, 32'h0,        0, 32'h0,             1, 32'h1C,        32'h18,       NOP,          0);
    add(0, 0, 1, 32'h100,      0, 32'h0,             1, 32'h1C,        32'h18,       NOP,          0);
    add(0, 0, 0, 32'h0,        1, w(32'h1C),         1, 32'h100,       32'h18,       NOP,          0);
    add(0, 0, 0, 32'h0,        1, w(32'h100),        1, 32'h104,       32'h100,      w(32'h100),   1);
    // branch coincident with ack
    add(0, 0, 1, 32'h200,      1, w(32'h104),        1, 32'h200,       32'h100,      NOP,          0);
    add(0, 0, 0, 32'h0,        1, w(32'h200),        1, 32'h204,       32'h200,      w(32'h200),   1);
    // branch and stall together in HOLD
    add(0, 1, 0, 32'h0,        1, w(32'h204),        0, 32'h204,       32'h200,      w(32'h200),   1);
    add(0, 1, 1, 32'h300,      0, 32'h0,             1, 32'h300,       32'h200,      NOP,          0);
    add(0, 0, 0, 32'h0,        1, w(32'h300),        1, 32'h304,       32'h300,      w(32'h300),   1);
    // killed ack under stall: IF/ID holds its bubble, refetch at target
    add(0, 0, 1, 32'h400,      0, 32'h0,             1, 32'h304,       32'h300,      NOP,          0);
    add(0, 1, 0, 32'h0,        1, w(32'h304),        1, 32'h400,       32'h300,      NOP,          0);
    add(0, 0, 0, 32'h0,        1, w(32'h400),        1, 32'h404,       32'h400,      w(32'h400),   1);
    // stall with no ack holds IF/ID
    add(0, 1, 0, 32'h0,        0, 32'h0,             1, 32'h404,       32'h400,      w(32'h400),   1);
    // address wrap at the top of memory
    add(0, 0, 1, 32'hFFFFFFFC, 1, w(32'h404),        1, 32'hFFFFFFFC,  32'h400,      NOP,          0);
    add(0, 0, 0, 32'h0,        1, 32'h12345678,      1, 32'h0,         32'hFFFFFFFC, 32'h12345678, 1);
    // newer branch while kill pending overwrites the redirect target
    add(0, 0, 1, 32'h500,      0, 32'h0,             1, 32'h0,         32'hFFFFFFFC, NOP,          0);
    add(0, 0, 1, 32'h600,      0, 32'h0,             1, 32'h0,         32'hFFFFFFFC, NOP,          0);
    add(0, 0, 0, 32'h0,        1, w(32'h0),          1, 32'h600,       32'hFFFFFFFC, NOP,          0);
    add(0, 0, 0, 32'h0,        1, w(32'h600),        1, 32'h604,       32'h600,      w(32'h600),   1);

    // reset state
    repeat (2) @(posedge clk_i);
    #1;
    check_outputs("in_reset", 1'b0, 32'h0, 32'h0, NOP, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    check_outputs("after_reset", 1'b0, 32'h0, 32'h0, NOP, 1'b0);
    @(negedge clk_i);

    foreach (vecs[i]) begin
      drive(vecs[i].start, vecs[i].stall, vecs[i].branch, vecs[i].target, vecs[i].ack, vecs[i].data);
      @(posedge clk_i); #1;
      check_outputs($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_addr,
                    vecs[i].exp_pc, vecs[i].exp_instr, vecs[i].exp_valid);
      $display("vec%0d st=%b sl=%b br=%b ack=%b -> req=%b addr=%h pc=%h instr=%h v=%b",
               i, vecs[i].start, vecs[i].stall, vecs[i].branch, vecs[i].ack,
               bus.imem_req_o, bus.imem_addr_o, IFID_pc_o, IFID_instr_o, IFID_valid_o);
      @(negedge clk_i);
    end

    // Async reset mid-request: req is high at 0x604 with nothing acked.
    drive(0, 0, 0, 32'h0, 0, 32'h0);
    #2;
    rst_i = 1'b0;
    #1;
    check_outputs("async_reset", 1'b0, 32'h0, 32'h0, NOP, 1'b0);
    $display("async_reset -> req=%b addr=%h v=%b", bus.imem_req_o, bus.imem_addr_o, IFID_valid_o);
    // A late ack during and after reset must be ignored.
    drive(0, 0, 0, 32'h0, 1, w(32'h604));
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    check_outputs("late_ack", 1'b0, 32'h0, 32'h0, NOP, 1'b0);
    $display("late_ack -> req=%b addr=%h v=%b", bus.imem_req_o, bus.imem_addr_o, IFID_valid_o);
    @(negedge clk_i);
    // Restart fetches from RESET_PC.
    drive(1, 0, 0, 32'h0, 0, 32'h0);
    @(posedge clk_i); #1;
    check_outputs("restart", 1'b1, 32'h0, 32'h0, NOP, 1'b0);
    $display("restart -> req=%b addr=%h", bus.imem_req_o, bus.imem_addr_o);
    @(negedge clk_i);
    drive(0, 0, 0, 32'h0, 1, 32'hCAFE0013);
    @(posedge clk_i); #1;
    check_outputs("restart_ack", 1'b1, 32'h4, 32'h0, 32'hCAFE0013, 1'b1);
    $display("restart_ack -> pc=%h instr=%h v=%b", IFID_pc_o, IFID_instr_o, IFID_valid_o);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
